// File: rtl/enc_pkg.sv
// Shared types and the RSC trellis step for the turbo constituent encoder.
// The step function doubles as the golden model in decoder and encoder benches.
package enc_pkg;

  localparam int LLR_W_DEF = 8;
  localparam int AMP_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic [LLR_W_DEF-1:0] par;
    logic [LLR_W_DEF-1:0] sys;
  } soft_pair_t;

  // state = {s2, s1, s0}; returns {next_state[2:0], a, z}
  function automatic logic [4:0] rsc_step(input logic [2:0] state, input logic u);
    logic a;
    logic z;
    a = u ^ state[1] ^ state[2];
    z = a ^ state[0] ^ state[2];
    return {state[1], state[0], a, a, z};
  endfunction

  function automatic int map_soft(input logic b, input int amp);
    return b ? -amp : amp;
  endfunction

endpackage

// File: rtl/rsc_trellis.sv
// Three-bit RSC trellis state with step, load and clear; in tail mode the
// input bit is forced to s1^s2 so the feedback drives the state to zero.
module rsc_trellis
  import enc_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       i_step,
  input  logic       i_tail,
  input  logic       i_u,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [2:0] i_load_state,
  output logic       o_u,
  output logic       o_z
);

  logic [2:0] r_state;
  logic       w_u;
  logic [4:0] w_step;
  logic       w_unused_a;

  assign w_u    = i_tail ? (r_state[1] ^ r_state[2]) : i_u;
  assign w_step = rsc_step(r_state, w_u);

  // a is already folded into the next s0, so it is not needed separately here
  assign w_unused_a = w_step[1];

  assign o_u = w_u;
  assign o_z = w_step[0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= 3'b000;
    end else if (i_clear) begin
      r_state <= 3'b000;
    end else if (i_load) begin
      r_state <= i_load_state;
    end else if (i_step) begin
      r_state <= w_step[4:2];
    end
  end

endmodule

// File: rtl/rsc_turbo_encoder.sv
// LTE RSC constituent encoder: per-bit (systematic, parity) soft pairs over
// AXI-Stream followed by three trellis-termination beats per frame.
module rsc_turbo_encoder
  import enc_pkg::*;
#(
  parameter int LLR_W    = LLR_W_DEF,
  parameter int AMP      = AMP_DEF,
  parameter int BLKLEN_W = 13
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [BLKLEN_W-1:0] blklen,
  input  logic                s_axis_bit_tdata,
  input  logic                s_axis_bit_tvalid,
  input  logic                s_axis_bit_tlast,
  output logic                s_axis_bit_tready,
  output logic [2*LLR_W-1:0]  m_axis_enc_tdata,
  output logic                m_axis_enc_tvalid,
  input  logic                m_axis_enc_tready,
  output logic [1:0]          m_axis_enc_tuser,
  output logic                m_axis_enc_tlast,
  output logic                err_tlast
);

  enc_state_t          r_state;
  enc_state_t          w_state_nxt;
  logic [BLKLEN_W-1:0] r_len;
  logic [BLKLEN_W-1:0] w_len_nxt;
  logic [BLKLEN_W-1:0] r_cnt;
  logic [BLKLEN_W-1:0] w_cnt_nxt;
  logic [1:0]          r_tail_cnt;
  logic [1:0]          w_tail_cnt_nxt;

  logic                r_out_valid;
  logic [2*LLR_W-1:0]  r_out_data;
  logic [1:0]          r_out_user;
  logic                r_out_last;
  logic                r_err;

  logic w_out_free;
  logic w_in_ready;
  logic w_accept;
  logic w_tail_fire;
  logic w_tail_done;
  logic w_step;
  logic w_exp_last;
  logic w_sof;
  logic w_u;
  logic w_z;

  // Ready is held low during reset so no beat slips in before the FSM is live
  assign w_out_free  = !r_out_valid || m_axis_enc_tready;
  assign w_in_ready  = aresetn && ((r_state == IDLE) || (r_state == DATA)) && w_out_free;
  assign w_accept    = s_axis_bit_tvalid && w_in_ready;
  assign w_tail_fire = (r_state == TAIL) && w_out_free;
  assign w_tail_done = w_tail_fire && (r_tail_cnt == 2'd2);
  assign w_step      = w_accept || w_tail_fire;
  assign w_sof       = w_accept && (r_state == IDLE);
  assign w_exp_last  = (r_state == IDLE) ? (blklen == BLKLEN_W'(1))
                                         : (r_cnt == (r_len - BLKLEN_W'(1)));

  rsc_trellis u_trellis (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .i_step       (w_step),
    .i_tail       (r_state == TAIL),
    .i_u          (s_axis_bit_tdata),
    .i_clear      (w_tail_done),
    .i_load       (1'b0),
    .i_load_state (3'b000),
    .o_u          (w_u),
    .o_z          (w_z)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_cnt_nxt      = r_cnt;
    w_tail_cnt_nxt = r_tail_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_len_nxt      = blklen;
          w_cnt_nxt      = BLKLEN_W'(1);
          w_tail_cnt_nxt = 2'd0;
          w_state_nxt    = (blklen == BLKLEN_W'(1)) ? TAIL : DATA;
        end
      end
      DATA: begin
        if (w_accept) begin
          w_cnt_nxt = r_cnt + BLKLEN_W'(1);
          if (w_exp_last) begin
            w_state_nxt    = TAIL;
            w_tail_cnt_nxt = 2'd0;
          end
        end
      end
      TAIL: begin
        if (w_tail_done) begin
          w_state_nxt    = IDLE;
          w_cnt_nxt      = '0;
          w_tail_cnt_nxt = 2'd0;
        end else if (w_tail_fire) begin
          w_tail_cnt_nxt = r_tail_cnt + 2'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_tail_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tail_cnt <= w_tail_cnt_nxt;
    end
  end

  // Single output register: reloads only when empty or being drained
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_user  <= 2'b00;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept && (s_axis_bit_tlast != w_exp_last);
      if (w_out_free) begin
        r_out_valid <= w_step;
        if (w_step) begin
          r_out_data <= {LLR_W'(map_soft(w_z, AMP)), LLR_W'(map_soft(w_u, AMP))};
          r_out_user <= {w_tail_fire, w_sof};
          r_out_last <= w_tail_done;
        end
      end
    end
  end

  assign s_axis_bit_tready = w_in_ready;
  assign m_axis_enc_tdata  = r_out_data;
  assign m_axis_enc_tvalid = r_out_valid;
  assign m_axis_enc_tuser  = r_out_user;
  assign m_axis_enc_tlast  = r_out_last;
  assign err_tlast         = r_err;

endmodule
